alu_writeback: RTL and testbench
================================

# alu_writeback

Result/flag write-back stage on the consuming side of the ALU. Accepts one ALU result per handshake (operation select, 32-bit result, z/c/v), buffers results in a small FIFO for the downstream register-file or bus consumer, and keeps the architectural NZCV flag register. It also keeps sticky overflow and illegal-op flags, and evaluates a selectable branch condition from the current flags. Sits directly after the ALU in the datapath.

## Interface

- DEPTH, 4, FIFO entries; power of two, at least 2
- W, 32, result width; must match the ALU result width
- elk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  ALU result presented
- in_ready  output  1  entry free; transfer occurs when in_valid && in_ready
- in_sel  input  3  ALU op code: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT, 101-111 illegal
- in_res  input  W  ALU result, two's complement
- in_z, in_c, in_v  input  1 each  ALU zero, carry and overflow flags
- out_valid  output  1  FIFO head valid
- out_ready  input  1  consumer accepts the head; pop occurs when out_valid && out_ready
- out_res  output  W  head result
- out_sel  output  3  head op code
- out_flags  output  4  head flags {n,z,c,v}; n = res[W-1]
- count  output  $clog2(DEPTH)+1  current occupancy
- flags  output  4  architectural NZCV register
- cond_sel  input  3  000 EQ(z), 001 NE, 010 CS(c), 011 CC, 100 MI(n), 101 PL, 110 VS(v), 111 VC
- cond_true  output  1  condition from cond_sel, evaluated on the `flags` register (combinational)
- ovf_sticky  output  1  set by an accepted ADD/SUB with v=1
- err_sticky  output  1  set by an accepted illegal op code
- clr_sticky  input  1  one-cycle pulse; clears both sticky bits

## Operation

- FIFO: circular buffer with separate read and write pointers, each log2(DEPTH) bits wide, plus `count`. Pointers wrap modulo DEPTH.
- Each entry stores {sel, res, n, z, c, v} exactly as received. Illegal op codes are stored too.
- `in_ready = (count != DEPTH)`. There is no pass-through when full: a pop and a push cannot both happen in the same cycle while full.
- Push only: `count` +1. Pop only: `count` −1. Push and pop together (not full, not empty): `count` unchanged, both pointers advance.
- `out_valid = (count != 0)`. `out_res`, `out_sel` and `out_flags` reflect the head entry. They hold their value while out_valid=1 and out_ready=0.
- Flag register update happens on accept and is independent of the FIFO pop side:
  - ADD/SUB: N, Z, C and V are all loaded.
  - AND/OR/NOT: N and Z are loaded; C and V are preserved.
  - Illegal op: flags are unchanged and err_sticky is set.
- Sticky bits: if a set and clr_sticky occur in the same cycle, the set wins.
- Reset (asynchronous, any time, including while the FIFO is partially full):
  - Pointers, count, flags, ovf_sticky and err_sticky go to 0.
  - out_valid=0 and in_ready=1.
  - FIFO storage contents are don't-care after reset.

## Timing

- Input to output latency is one cycle. An entry pushed at edge k into an empty FIFO gives out_valid=1 after edge k, with the data visible in that cycle.
- `flags`, `cond_true` and the sticky bits reflect an accepted input after the same edge that accepts it.
- Throughput is one transfer per cycle on each side in steady state.
- When full with out_ready=1, in_ready rises the cycle after the pop.
- Output values while out_valid=0 are don't-care. The bench must not check them.
- All state changes on the rising edge of elk, except asynchronous reset.

## Test plan

- Reset then single ADD:
  - Stimulus: in_sel=000, in_res=5, z=0, c=1, v=0 (result of 7 + (−2)), with out_ready=1.
  - Required: after one edge, out_valid=1, out_res=5, out_flags=0010, flags=0010, cond_true(CS)=1. The FIFO is empty again after the next edge.
- Logical ops preserve C and V:
  - Stimulus: ADD 0x7FFFFFFF+1 → res=0x80000000, z=0, c=0, v=1, then AND 10&0 → res=0, z=1, c=0, v=0.
  - Required: after the ADD, flags=1001 and ovf_sticky=1. After the AND, flags=0101. cond_true(VS)=1 and cond_true(EQ)=1.
- Fill and backpressure:
  - Stimulus: push 4 SUB results (8, 0, 0, 0xFFFFFFFE) with out_ready=0.
  - Required: count=4, in_ready=0. A 5th presented value is not accepted. Drain order is 8, 0, 0, 0xFFFFFFFE, and in_ready returns to 1 the cycle after the first pop.
- Simultaneous push and pop:
  - Stimulus: with count=2, assert in_valid and out_ready for 3 cycles.
  - Required: count stays 2, output order is preserved, and the pointers wrap past DEPTH−1 correctly.
- Illegal op and sticky clear:
  - Stimulus: in_sel=110, then assert clr_sticky in the same cycle as an ADD with v=1.
  - Required: err_sticky=1 and flags unchanged after the illegal op. The entry is still output with out_sel=110. After the ADD/clear cycle, ovf_sticky=1 and err_sticky=0.
- Reset mid-operation:
  - Stimulus: deassert rst_n asynchronously with count=3 and flags=1001.
  - Required: immediately out_valid=0, count=0, flags=0000, stickies=0, in_ready=1. After release, the first push appears after one edge.

Source files
------------

// File: rtl/alu_writeback.sv
// ALU write-back stage: result FIFO, NZCV flag register,
// sticky overflow/illegal-op bits and branch condition evaluation.
module alu_writeback #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                       elk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_sel,
  input  logic [W-1:0]               in_res,
  input  logic                       in_z,
  input  logic                       in_c,
  input  logic                       in_v,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W-1:0]               out_res,
  output logic [2:0]                 out_sel,
  output logic [3:0]                 out_flags,
  output logic [$clog2(DEPTH):0]     count,
  output logic [3:0]                 flags,
  input  logic [2:0]                 cond_sel,
  output logic                       cond_true,
  output logic                       ovf_sticky,
  output logic                       err_sticky,
  input  logic                       clr_sticky
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [2:0]   sel;
    logic [W-1:0] res;
    logic [3:0]   nzcv;
  } ent_t;

  ent_t          mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    flg_q, flg_d;
  logic          ovf_q, ovf_d;
  logic          err_q, err_d;

  logic push, pop;
  logic is_arith, is_logic;
  logic in_n;
  logic cond_base;
  ent_t in_ent, head;

  assign in_ready  = (cnt_q != CW'(DEPTH));
  assign out_valid = (cnt_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign in_n      = in_res[W-1];

  assign in_ent.sel  = in_sel;
  assign in_ent.res  = in_res;
  assign in_ent.nzcv = {in_n, in_z, in_c, in_v};

  assign head      = mem_q[rd_q];
  assign out_res   = head.res;
  assign out_sel   = head.sel;
  assign out_flags = head.nzcv;

  assign count      = cnt_q;
  assign flags      = flg_q;
  assign ovf_sticky = ovf_q;
  assign err_sticky = err_q;

  assign is_arith = (in_sel == 3'b000) || (in_sel == 3'b001);
  assign is_logic = (in_sel == 3'b010) || (in_sel == 3'b011)
                 || (in_sel == 3'b100);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) wr_d = wr_q + AW'(1);
    if (pop)  rd_d = rd_q + AW'(1);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Logical ops leave C and V from the last arithmetic op intact.
  always_comb begin
    flg_d = flg_q;
    unique case (1'b1)
      push && is_arith: flg_d = {in_n, in_z, in_c, in_v};
      push && is_logic: flg_d = {in_n, in_z, flg_q[1:0]};
      default:          flg_d = flg_q;
    endcase
  end

  // A set in the same cycle as a clear wins.
  always_comb begin
    ovf_d = (clr_sticky ? 1'b0 : ovf_q) | (push & is_arith & in_v);
    err_d = (clr_sticky ? 1'b0 : err_q)
          | (push & ~is_arith & ~is_logic);
  end

  always_comb begin
    cond_base = 1'b0;
    unique case (cond_sel[2:1])
      2'b00:   cond_base = flg_q[2];
      2'b01:   cond_base = flg_q[1];
      2'b10:   cond_base = flg_q[3];
      default: cond_base = flg_q[0];
    endcase
  end

  assign cond_true = cond_base ^ cond_sel[0];

  always_ff @(posedge elk) begin
    if (push) mem_q[wr_q] <= in_ent;
  end

  always_ff @(posedge elk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      flg_q <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      flg_q <= flg_d;
      ovf_q <= ovf_d;
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: handshake, FIFO order,
// flag update rules, sticky bits and async reset.
module tb_alu_writeback;

  logic        elk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_sel;
  logic [31:0] in_res;
  logic        in_z, in_c, in_v;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic [2:0]  out_sel;
  logic [3:0]  out_flags;
  logic [2:0]  count;
  logic [3:0]  flags;
  logic [2:0]  cond_sel;
  logic        cond_true;
  logic        ovf_sticky;
  logic        err_sticky;
  logic        clr_sticky;

  int checks = 0;
  int failures = 0;

  alu_writeback #(.DEPTH(4), .W(32)) dut (
    .elk        (elk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_res     (in_res),
    .in_z       (in_z),
    .in_c       (in_c),
    .in_v       (in_v),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_res    (out_res),
    .out_sel    (out_sel),
    .out_flags  (out_flags),
    .count      (count),
    .flags      (flags),
    .cond_sel   (cond_sel),
    .cond_true  (cond_true),
    .ovf_sticky (ovf_sticky),
    .err_sticky (err_sticky),
    .clr_sticky (clr_sticky)
  );

  always #5 elk = ~elk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge elk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] s,
                       input logic [31:0] r, input logic z,
                       input logic c, input logic ov);
    in_valid = v;
    in_sel   = s;
    in_res   = r;
    in_z     = z;
    in_c     = c;
    in_v     = ov;
  endtask

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b0;
    cond_sel = 3'b000;
    clr_sticky = 1'b0;
    drive(1'b0, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_ovf", 32'(ovf_sticky), 32'd0);
    chk("rst_err", 32'(err_sticky), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // single ADD 7 + (-2)
    out_ready = 1'b1;
    cond_sel = 3'b010;
    drive(1'b1, 3'b000, 32'd5, 1'b0, 1'b1, 1'b0);
    step();
    chk("add_out_valid", 32'(out_valid), 32'd1);
    chk("add_out_res", out_res, 32'd5);
    chk("add_out_flags", 32'(out_flags), 32'b0010);
    chk("add_flags", 32'(flags), 32'b0010);
    chk("add_cs", 32'(cond_true), 32'd1);
    in_valid = 1'b0;
    step();
    chk("add_empty", 32'(out_valid), 32'd0);
    chk("add_count0", 32'(count), 32'd0);

    // overflowing ADD then AND keeps C/V
    drive(1'b1, 3'b000, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    step();
    chk("ovf_flags", 32'(flags), 32'b1001);
    chk("ovf_sticky", 32'(ovf_sticky), 32'd1);
    drive(1'b1, 3'b010, 32'h0, 1'b1, 1'b0, 1'b0);
    cond_sel = 3'b110;
    step();
    chk("and_flags", 32'(flags), 32'b0101);
    chk("and_vs", 32'(cond_true), 32'd1);
    cond_sel = 3'b000;
    #1;
    chk("and_eq", 32'(cond_true), 32'd1);
    cond_sel = 3'b111;
    #1;
    chk("and_vc", 32'(cond_true), 32'd0);
    in_valid = 1'b0;
    step();
    chk("and_drained", 32'(count), 32'd0);

    // fill with SUB results under backpressure
    out_ready = 1'b0;
    drive(1'b1, 3'b001, 32'd8, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b1, 3'b001, 32'd0, 1'b1, 1'b1, 1'b0);
    step();
    step();
    drive(1'b1, 3'b001, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    step();
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_flags", 32'(flags), 32'b1000);
    drive(1'b1, 3'b001, 32'h0000_0123, 1'b0, 1'b0, 1'b0);
    step();
    chk("full_reject_count", 32'(count), 32'd4);
    chk("full_head_hold", out_res, 32'd8);
    chk("full_head_flags", 32'(out_flags), 32'b0010);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("drain1_in_ready", 32'(in_ready), 32'd1);
    chk("drain1_count", 32'(count), 32'd3);
    chk("drain1_res", out_res, 32'd0);
    chk("drain1_flags", 32'(out_flags), 32'b0110);
    step();
    chk("drain2_res", out_res, 32'd0);
    step();
    chk("drain3_res", out_res, 32'hFFFF_FFFE);
    chk("drain3_flags", 32'(out_flags), 32'b1000);
    step();
    chk("drain4_empty", 32'(out_valid), 32'd0);

    // push+pop at count=2 across the pointer wrap
    out_ready = 1'b0;
    drive(1'b1, 3'b011, 32'h11, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 3'b011, 32'h22, 1'b0, 1'b0, 1'b0);
    step();
    chk("pp_count2", 32'(count), 32'd2);
    chk("pp_head0", out_res, 32'h11);
    out_ready = 1'b1;
    drive(1'b1, 3'b011, 32'h33, 1'b0, 1'b0, 1'b0);
    step();
    chk("pp1_count", 32'(count), 32'd2);
    chk("pp1_head", out_res, 32'h22);
    drive(1'b1, 3'b011, 32'h44, 1'b0, 1'b0, 1'b0);
    step();
    chk("pp2_count", 32'(count), 32'd2);
    chk("pp2_head", out_res, 32'h33);
    drive(1'b1, 3'b011, 32'h55, 1'b0, 1'b0, 1'b0);
    step();
    chk("pp3_count", 32'(count), 32'd2);
    chk("pp3_head", out_res, 32'h44);
    in_valid = 1'b0;
    step();
    chk("pp4_head", out_res, 32'h55);
    chk("pp4_count", 32'(count), 32'd1);
    step();
    chk("pp_empty", 32'(count), 32'd0);

    // illegal op, then set-wins-over-clear
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    chk("clr_ovf", 32'(ovf_sticky), 32'd0);
    out_ready = 1'b0;
    drive(1'b1, 3'b000, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    step();
    chk("pre_ill_flags", 32'(flags), 32'b1010);
    drive(1'b1, 3'b110, 32'h7, 1'b1, 1'b0, 1'b1);
    step();
    chk("ill_flags", 32'(flags), 32'b1010);
    chk("ill_err", 32'(err_sticky), 32'd1);
    chk("ill_ovf", 32'(ovf_sticky), 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("ill_out_sel", 32'(out_sel), 32'b110);
    chk("ill_out_res", out_res, 32'h7);
    chk("ill_out_flags", 32'(out_flags), 32'b0101);
    drive(1'b1, 3'b000, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    chk("setclr_ovf", 32'(ovf_sticky), 32'd1);
    chk("setclr_err", 32'(err_sticky), 32'd0);
    chk("setclr_flags", 32'(flags), 32'b1001);
    chk("setclr_count", 32'(count), 32'd1);

    // async reset with three entries queued
    out_ready = 1'b0;
    step();
    step();
    in_valid = 1'b0;
    chk("pre_rst_count", 32'(count), 32'd3);
    chk("pre_rst_flags", 32'(flags), 32'b1001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_flags", 32'(flags), 32'd0);
    chk("arst_ovf", 32'(ovf_sticky), 32'd0);
    chk("arst_err", 32'(err_sticky), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    step();
    rst_n = 1'b1;
    step();
    drive(1'b1, 3'b000, 32'h9, 1'b0, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_res", out_res, 32'h9);
    chk("post_rst_count", 32'(count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
